// File: rtl/fc_event_dispatcher.sv
// -----------------------------------------------------------------------------
// fc_event_dispatcher
//
// Purpose:
//   Front end for the FC event FIFO. It collects single-cycle event pulses from
//   NB_EVENTS sources and keeps a saturating pending count for each source. It
//   picks pending, unmasked sources in round-robin order and presents one event
//   ID per valid/ready handshake. Events are not lost while the consumer
//   applies back-pressure, unless a counter is already saturated.
//
// Ports:
//   clk_i        in   1               clock
//   rst_ni       in   1               asynchronous reset, active low
//   events_i     in   NB_EVENTS       event pulses; each high cycle is one event
//   evt_mask_i   in   NB_EVENTS       1 = source disabled; its new events are dropped
//   evt_valid_o  out  1               event ID available
//   evt_data_o   out  EVENT_ID_WIDTH  event ID (source index + EVT_ID_OFFSET)
//   evt_fulln_i  in   1               consumer not full (ready)
//   overflow_o   out  NB_EVENTS       sticky lost-event flags
//   ovf_clr_i    in   1               clears all overflow_o bits
//
// Configuration macro:
//   FC_EVT_OVERFLOW_EN - when defined, builds the sticky overflow flags.
//                        When undefined, overflow_o is tied to 0 and
//                        ovf_clr_i is ignored.
// -----------------------------------------------------------------------------
module fc_event_dispatcher #(
    parameter int unsigned NB_EVENTS      = 32,
    parameter int unsigned EVENT_ID_WIDTH = 8,
    parameter int unsigned EVT_ID_OFFSET  = 0,
    parameter int unsigned CNT_WIDTH      = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_EVENTS-1:0]      events_i,
    input  logic [NB_EVENTS-1:0]      evt_mask_i,
    output logic                      evt_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
    input  logic                      evt_fulln_i,
    output logic [NB_EVENTS-1:0]      overflow_o,
    input  logic                      ovf_clr_i
);

    localparam int unsigned          PTR_W   = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;
    localparam logic [PTR_W:0]       NB_W    = (PTR_W+1)'(NB_EVENTS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // The highest ID must fit in the output width.
    if ((64'(NB_EVENTS) - 64'd1 + 64'(EVT_ID_OFFSET)) >= (64'd1 << EVENT_ID_WIDTH)) begin : g_bad_id_width
        $error("fc_event_dispatcher: NB_EVENTS-1+EVT_ID_OFFSET does not fit in EVENT_ID_WIDTH");
    end
    if (NB_EVENTS < 1 || NB_EVENTS > 256) begin : g_bad_nb_events
        $error("fc_event_dispatcher: NB_EVENTS must be in 1..256");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [CNT_WIDTH-1:0]      r_cnt [NB_EVENTS];
    logic [PTR_W-1:0]          r_ptr;
    logic [EVENT_ID_WIDTH-1:0] r_data;

    logic [NB_EVENTS-1:0]      w_elig;
    logic [NB_EVENTS-1:0]      w_inc;
    logic [NB_EVENTS-1:0]      w_dec;
    logic [NB_EVENTS-1:0]      w_rot;
    logic [PTR_W-1:0]          w_off;
    logic [PTR_W:0]            w_sum;
    logic [PTR_W:0]            w_sel_p1;
    logic [PTR_W-1:0]          w_sel;
    logic                      w_any;
    logic                      w_transfer;
    logic                      w_load;

    // ---------------------------------------------------------------------
    // Eligibility and round-robin selection
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NB_EVENTS; k++) begin
            w_elig[k] = (r_cnt[k] != '0) && !evt_mask_i[k];
        end
    end

    assign w_inc = events_i & ~evt_mask_i;
    assign w_any = |w_elig;

    // Rotate the eligible vector so that bit 0 corresponds to the pointer.
    // The lowest set bit is then the cyclic distance from the pointer.
    assign w_rot = NB_EVENTS'({w_elig, w_elig} >> r_ptr);

    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment; otherwise a latch is inferred.
    always_comb begin
        w_off = '0;
        for (int i = NB_EVENTS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PTR_W'(i);
            end
        end
    end

    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel    = (w_sum >= NB_W) ? PTR_W'(w_sum - NB_W) : PTR_W'(w_sum);
    assign w_sel_p1 = {1'b0, w_sel} + 1'b1;

    assign w_transfer = (r_state == ST_FULL) && evt_fulln_i;
    assign w_load     = w_any && ((r_state == ST_EMPTY) || w_transfer);

    always_comb begin
        for (int k = 0; k < NB_EVENTS; k++) begin
            w_dec[k] = w_load && (w_sel == PTR_W'(k));
        end
    end

    // ---------------------------------------------------------------------
    // Output-stage FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_any)                    w_state_nxt = ST_FULL;
            ST_FULL:  if (w_transfer && !w_any)     w_state_nxt = ST_EMPTY;
            default:                                w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        evt_valid_o = (r_state == ST_FULL);
    end

    assign evt_data_o = r_data;

    // ---------------------------------------------------------------------
    // Held ID and round-robin pointer; both change only on a load.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr  <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_ptr  <= (w_sel_p1 == NB_W) ? '0 : PTR_W'(w_sel_p1);
            r_data <= EVENT_ID_WIDTH'(w_sel) + EVENT_ID_WIDTH'(EVT_ID_OFFSET);
        end
    end

    // ---------------------------------------------------------------------
    // Pending counters. A new event and a load of the same source in the
    // same cycle cancel out. A saturated counter drops the new event.
    // ---------------------------------------------------------------------
    // NOTE: the counter array is reset explicitly because a reset must
    // discard every pending event. It is a register array, not a RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NB_EVENTS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NB_EVENTS; k++) begin
                if (w_inc[k] && !w_dec[k] && (r_cnt[k] != CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end else if (w_dec[k] && !w_inc[k]) begin
                    r_cnt[k] <= r_cnt[k] - 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sticky overflow flags
    // ---------------------------------------------------------------------
`ifdef FC_EVT_OVERFLOW_EN
    logic [NB_EVENTS-1:0] r_ovf;
    logic [NB_EVENTS-1:0] w_lost;

    always_comb begin
        for (int k = 0; k < NB_EVENTS; k++) begin
            w_lost[k] = w_inc[k] && !w_dec[k] && (r_cnt[k] == CNT_MAX);
        end
    end

    // If a set and a clear occur in the same cycle, the set wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{NB_EVENTS{ovf_clr_i}}) | w_lost;
        end
    end

    assign overflow_o = r_ovf;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr_i;
    assign overflow_o       = '0;
`endif

endmodule

// File: tb/tb_fc_event_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_fc_event_dispatcher
//
// Self-checking bench for fc_event_dispatcher with default parameters
// (32 sources, 8-bit IDs, offset 0, 2-bit counters). A cycle-level reference
// model follows the dispatch rules using integer counts and a pointer. It is
// compared against the DUT outputs on every falling edge. Directed scenarios
// are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fc_event_dispatcher;

    localparam int NB   = 32;
    localparam int CMAX = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NB-1:0]   events_i = '0;
    logic [NB-1:0]   evt_mask_i = '0;
    logic            evt_valid_o;
    logic [7:0]      evt_data_o;
    logic            evt_fulln_i = 1'b1;
    logic [NB-1:0]   overflow_o;
    logic            ovf_clr_i = 1'b0;

    fc_event_dispatcher dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .events_i    (events_i),
        .evt_mask_i  (evt_mask_i),
        .evt_valid_o (evt_valid_o),
        .evt_data_o  (evt_data_o),
        .evt_fulln_i (evt_fulln_i),
        .overflow_o  (overflow_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_cnt [NB];
    int            m_ptr;
    bit            m_valid;
    int            m_data;
    logic [NB-1:0] m_ovf;

    // IDs actually handed over at rising edges
    int xfer_ids [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) m_cnt[k] = 0;
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 0;
        m_ovf   = '0;
    endtask

    // Advance the model by one rising edge, using the current inputs.
    task automatic model_step();
        int            sel;
        int            idx;
        bit            found;
        bit            xfer;
        bit            load;
        bit            inc;
        bit            dec;
        logic [NB-1:0] lost;
        xfer  = m_valid && evt_fulln_i;
        found = 0;
        sel   = 0;
        for (int j = 0; j < NB; j++) begin
            idx = (m_ptr + j) % NB;
            if (!found && m_cnt[idx] > 0 && !evt_mask_i[idx]) begin
                found = 1;
                sel   = idx;
            end
        end
        load = found && (!m_valid || xfer);
        lost = '0;
        for (int k = 0; k < NB; k++) begin
            inc = events_i[k] && !evt_mask_i[k];
            dec = load && (sel == k);
            if (inc && !dec) begin
                if (m_cnt[k] == CMAX) lost[k] = 1'b1;
                else                  m_cnt[k]++;
            end else if (dec && !inc) begin
                m_cnt[k]--;
            end
        end
        if (load) begin
            m_data = sel;
            m_ptr  = (sel + 1) % NB;
        end
        m_valid = load || (m_valid && !xfer);
        m_ovf   = (m_ovf & ~{NB{ovf_clr_i}}) | lost;
    endtask

    task automatic check_outputs(input string tag);
        logic [NB-1:0] exp_ovf;
`ifdef FC_EVT_OVERFLOW_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = '0;
`endif
        check({tag, "_valid"}, evt_valid_o, m_valid);
        if (m_valid) check({tag, "_data"}, evt_data_o, m_data);
        check({tag, "_ovf"}, overflow_o, exp_ovf);
    endtask

    // One clock: record any handshake, step the model, then compare at the falling edge.
    task automatic step(input string tag = "cyc");
        if (evt_valid_o && evt_fulln_i) xfer_ids.push_back(int'(evt_data_o));
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    task automatic cycle(input logic [NB-1:0] ev, input string tag = "cyc");
        events_i = ev;
        step(tag);
        events_i = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("rst_valid", evt_valid_o, 1'b0);
        check("rst_data", evt_data_o, 8'd0);
        check("rst_ovf", overflow_o, '0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk_i);
        do_reset();

        // 1: single pulse on source 5, visible two edges later for one cycle
        evt_fulln_i = 1'b1;
        cycle(NB'(1) << 5, "t1a");
        check("t1_not_yet", evt_valid_o, 1'b0);
        cycle('0, "t1b");
        check("t1_valid", evt_valid_o, 1'b1);
        check("t1_id", evt_data_o, 8'd5);
        cycle('0, "t1c");
        check("t1_one_cycle", evt_valid_o, 1'b0);

        // 2: sources 3, 7, 30 together, then 0 and 31 to show the wrap from 31
        do_reset();
        xfer_ids.delete();
        cycle((NB'(1) << 3) | (NB'(1) << 7) | (NB'(1) << 30), "t2");
        idle(5);
        check("t2_count", xfer_ids.size(), 3);
        if (xfer_ids.size() == 3) begin
            check("t2_id0", xfer_ids[0], 3);
            check("t2_id1", xfer_ids[1], 7);
            check("t2_id2", xfer_ids[2], 30);
        end
        xfer_ids.delete();
        cycle((NB'(1) << 0) | (NB'(1) << 31), "t2w");
        idle(4);
        check("t2w_count", xfer_ids.size(), 2);
        if (xfer_ids.size() == 2) begin
            check("t2w_first", xfer_ids[0], 31);
            check("t2w_second", xfer_ids[1], 0);
        end

        // 3: back-pressure holds ID 0, then exactly two transfers
        do_reset();
        evt_fulln_i = 1'b0;
        cycle(NB'(1), "t3");
        cycle('0, "t3");
        cycle(NB'(1), "t3");
        idle(7);
        check("t3_hold_valid", evt_valid_o, 1'b1);
        check("t3_hold_data", evt_data_o, 8'd0);
        xfer_ids.delete();
        evt_fulln_i = 1'b1;
        idle(6);
        check("t3_count", xfer_ids.size(), 2);
        foreach (xfer_ids[i]) check("t3_id", xfer_ids[i], 0);

        // 4: saturation on source 9 with the output blocked
        do_reset();
        evt_fulln_i = 1'b0;
        for (int i = 0; i < 5; i++) cycle(NB'(1) << 9, "t4");
        idle(3);
`ifdef FC_EVT_OVERFLOW_EN
        check("t4_ovf_set", overflow_o[9], 1'b1);
        ovf_clr_i = 1'b1;
        cycle('0, "t4clr");
        ovf_clr_i = 1'b0;
        check("t4_ovf_clr", overflow_o[9], 1'b0);
`else
        check("t4_ovf_off", overflow_o, '0);
`endif
        xfer_ids.delete();
        evt_fulln_i = 1'b1;
        idle(8);
        check("t4_count", xfer_ids.size(), 4);
        foreach (xfer_ids[i]) check("t4_id", xfer_ids[i], 9);

        // 5: a masked pulse is dropped; a pending count waits while its source is masked
        do_reset();
        xfer_ids.delete();
        evt_mask_i = NB'(1) << 4;
        cycle(NB'(1) << 4, "t5");
        idle(4);
        check("t5_masked_none", xfer_ids.size(), 0);
        evt_mask_i  = '0;
        evt_fulln_i = 1'b0;
        cycle(NB'(1) << 1, "t5");
        cycle('0, "t5");
        cycle(NB'(1) << 2, "t5");
        evt_mask_i  = NB'(1) << 2;
        evt_fulln_i = 1'b1;
        idle(5);
        check("t5_only_held", xfer_ids.size(), 1);
        if (xfer_ids.size() >= 1) check("t5_held_id", xfer_ids[0], 1);
        evt_mask_i = '0;
        idle(4);
        check("t5_after_unmask", xfer_ids.size(), 2);
        if (xfer_ids.size() >= 2) check("t5_unmask_id", xfer_ids[1], 2);

        // 6: reset while valid with pending counts; nothing stale afterwards
        do_reset();
        evt_fulln_i = 1'b0;
        cycle(NB'(1) << 6, "t6");
        cycle(NB'(1) << 6, "t6");
        cycle(NB'(1) << 6, "t6");
        check("t6_pre_valid", evt_valid_o, 1'b1);
        do_reset();
        evt_fulln_i = 1'b1;
        xfer_ids.delete();
        idle(5);
        check("t6_no_stale", xfer_ids.size(), 0);

        // Randomized phase checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) evt_mask_i = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0)  evt_fulln_i = ~evt_fulln_i;
            ovf_clr_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 599) == 0) begin
                ovf_clr_i = 1'b0;
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                cycle($urandom & $urandom, "rnd");
            end else begin
                cycle($urandom & $urandom & $urandom & $urandom, "rnd");
            end
        end
        ovf_clr_i   = 1'b0;
        evt_mask_i  = '0;
        evt_fulln_i = 1'b1;
        idle(140);
        check("rnd_drained", evt_valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
